// File: rtl/cdud_bcd_n_if.sv
// Control/data bundle for the N-digit BCD up/down counter.
// The master drives the synchronous controls and the load data.
// The slave (the counter) returns the count, the carry-out and the illegal-digit flag.
//   cs   : synchronous clear          ld   : synchronous parallel load
//   en   : count enable               cai  : carry-in (cascade input)
//   dnup : 0 = count up, 1 = count down
//   d    : load data, 4 bits per digit, digit 0 least significant
//   q    : count value, same layout as d
//   cao  : combinational carry-out    ill  : combinational, some digit of q > 9
interface cdud_bcd_n_if #(
    parameter int DIGITS = 4
);
    logic                  cs;
    logic                  ld;
    logic                  en;
    logic                  cai;
    logic                  dnup;
    logic [4*DIGITS-1:0]   d;
    logic [4*DIGITS-1:0]   q;
    logic                  cao;
    logic                  ill;

    modport master (
        output cs, ld, en, cai, dnup, d,
        input  q, cao, ill
    );

    modport slave (
        input  cs, ld, en, cai, dnup, d,
        output q, cao, ill
    );
endinterface

// File: rtl/cdud_bcd_n.sv
// Purpose: N-digit cascadable BCD up/down counter with clear, load, enable and carry in/out.
// Latency: q updates one edge after cs/ld/step; async clear immediate; cao/ill combinational.
// Backpressure: none; a step needs en & cai, and any illegal digit freezes counting.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous clear, active-low; forces q to zero, masks cao and ill
//   s_bus   : cdud_bcd_n_if.slave (cs, ld, en, cai, dnup, d -> q, cao, ill)
module cdud_bcd_n #(
    parameter int DIGITS = 4,
    parameter int SAT    = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    cdud_bcd_n_if.slave   s_bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]    r_q;
    logic [W-1:0]    w_q_step;
    // w_all9[k] / w_all0[k]: every digit below k is 9 / 0. Index DIGITS covers the whole word.
    logic [DIGITS:0] w_all9;
    logic [DIGITS:0] w_all0;
    logic            w_ill;
    logic            w_tc;
    logic            w_step;
    logic            w_adv;

    always_comb begin
        w_q_step  = r_q;
        w_all9    = '0;
        w_all0    = '0;
        w_ill     = 1'b0;
        w_all9[0] = 1'b1;
        w_all0[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            w_all9[k+1] = w_all9[k] & (r_q[4*k +: 4] == 4'd9);
            w_all0[k+1] = w_all0[k] & (r_q[4*k +: 4] == 4'd0);
            w_ill       = w_ill | (r_q[4*k +: 4] > 4'd9);
            // The whole carry/borrow chain resolves in one cycle.
            if (s_bus.dnup) begin
                if (w_all0[k]) begin
                    w_q_step[4*k +: 4] = (r_q[4*k +: 4] == 4'd0) ? 4'd9
                                                                 : 4'(r_q[4*k +: 4] - 4'd1);
                end
            end else begin
                if (w_all9[k]) begin
                    w_q_step[4*k +: 4] = (r_q[4*k +: 4] == 4'd9) ? 4'd0
                                                                 : 4'(r_q[4*k +: 4] + 4'd1);
                end
            end
        end
        w_tc   = s_bus.dnup ? w_all0[DIGITS] : w_all9[DIGITS];
        w_step = s_bus.en & s_bus.cai & ~w_ill;
        // In saturate mode a step at terminal count leaves the value alone,
        // while cao still reports the terminal count exactly as in wrap mode.
        w_adv  = w_step & ~((SAT != 0) & w_tc);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (s_bus.cs) begin
            r_q <= '0;
        end else if (s_bus.ld) begin
            r_q <= s_bus.d;
        end else if (w_adv) begin
            r_q <= w_q_step;
        end
    end

    assign s_bus.q   = r_q;
    // During the async clear q is zero, which is terminal count when counting
    // down; gating with the reset keeps cao low regardless of direction.
    assign s_bus.cao = i_rst_n & w_step & w_tc;
    assign s_bus.ill = i_rst_n & w_ill;
endmodule
